form_error_block: RTL and testbench

FORM_ERROR_BLOCK -- requirements
Module: form_error_block

---
 rtl/form_error_block.sv | 47 ++++
 tb/tb_form_error_block.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/form_error_block.sv
// Form error detector: flags a dominant sample on the CRC or ACK delimiter.
// Define FORM_ERROR_STICKY_EN to hold the error until reset; otherwise it is re-evaluated every bit.
module form_error_block (
  input  logic SP,
  input  logic reset,
  input  logic RX,
  input  logic F_CRC_D,
  input  logic F_ACK_D,
  output logic FORM_Error
);

  // A dominant level on either fixed-form delimiter; both flags together still count once.
  function automatic logic form_violation(input logic rx, input logic crc_d, input logic ack_d);
    return (crc_d | ack_d) & ~rx;
  endfunction

  logic violation_s;
  logic form_error_next_s;
  logic form_error_r;

  // Next-state computation for the error flag.
  always_comb begin
    violation_s       = form_violation(RX, F_CRC_D, F_ACK_D);
    form_error_next_s = 1'b0;
`ifdef FORM_ERROR_STICKY_EN
    if (form_error_r) begin
      form_error_next_s = 1'b1;
    end else begin
      form_error_next_s = violation_s;
    end
`else
    form_error_next_s = violation_s;
`endif
  end

  // Error flag register, cleared asynchronously by reset.
  always_ff @(posedge SP or posedge reset) begin
    if (reset) begin
      form_error_r <= 1'b0;
    end else begin
      form_error_r <= form_error_next_s;
    end
  end

  assign FORM_Error = form_error_r;

endmodule

// File: tb/tb_form_error_block.sv
// Directed self-checking bench for form_error_block; expectations follow FORM_ERROR_STICKY_EN.
module tb_form_error_block;

  logic SP;
  logic reset;
  logic RX;
  logic F_CRC_D;
  logic F_ACK_D;
  logic FORM_Error;

  int n_vec  = 0;
  int n_miss = 0;

`ifdef FORM_ERROR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  form_error_block dut (
    .SP         (SP),
    .reset      (reset),
    .RX         (RX),
    .F_CRC_D    (F_CRC_D),
    .F_ACK_D    (F_ACK_D),
    .FORM_Error (FORM_Error)
  );

  // One bit period: rising SP edge, then hold low; outputs are sampled mid-low phase.
  task automatic sp_edge();
    #5 SP = 1'b1;
    #5 SP = 1'b0;
    #2;
  endtask

  task automatic check(input string tag, input logic exp);
    n_vec++;
    assert (FORM_Error === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %b expected %b", tag, FORM_Error, exp);
    end
  endtask

  task automatic set_in(input logic rx, input logic crc, input logic ack);
    RX      = rx;
    F_CRC_D = crc;
    F_ACK_D = ack;
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    #1;
  endtask

  initial begin
    SP = 1'b0;
    reset = 1'b1;
    set_in(1'b0, 1'b1, 1'b0);
    #3;
    check("reset_initial", 1'b0);

    // Violation present while reset is held: edges ignored.
    for (int i = 0; i < 3; i++) begin
      sp_edge();
      check("reset_priority", 1'b0);
    end

    // First edge after release detects normally.
    reset = 1'b0;
    sp_edge();
    check("first_edge_after_reset", 1'b1);

    // Asynchronous clear between edges.
    #1 reset = 1'b1;
    #1;
    check("async_clear_immediate", 1'b0);
    reset = 1'b0;
    #1;
    check("async_clear_released", 1'b0);

    // Clean CRC delimiter for five bits.
    set_in(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      sp_edge();
      check("clean_crc_delim", 1'b0);
    end

    // CRC delimiter violation, then a clean delimiter bit.
    set_in(1'b0, 1'b1, 1'b0);
    sp_edge();
    check("crc_violation", 1'b1);
    set_in(1'b1, 1'b1, 1'b0);
    sp_edge();
    check("crc_next_clean", STICKY);

    pulse_reset();
    check("clear_after_crc", 1'b0);

    // ACK delimiter violation, then dominant bit with no flags.
    set_in(1'b0, 1'b0, 1'b1);
    sp_edge();
    check("ack_violation", 1'b1);
    set_in(1'b0, 1'b0, 1'b0);
    sp_edge();
    check("ack_then_no_flags", STICKY);

    pulse_reset();

    // Both flags at once: a single ordinary violation.
    set_in(1'b0, 1'b1, 1'b1);
    sp_edge();
    check("both_flags_violation", 1'b1);

    pulse_reset();

    // No flags, dominant: no error from a clear state.
    set_in(1'b0, 1'b0, 1'b0);
    sp_edge();
    check("no_flags_dominant", 1'b0);

    // Recessive with both flags: no error.
    set_in(1'b1, 1'b1, 1'b1);
    sp_edge();
    check("recessive_both_flags", 1'b0);

    // Glitch between edges must not be seen.
    set_in(1'b0, 1'b1, 1'b0);
    #1;
    check("between_edge_glitch", 1'b0);
    set_in(1'b1, 1'b1, 1'b0);
    sp_edge();
    check("glitch_not_sampled", 1'b0);

    // Latched error, async clear mid-frame, stays clear until next violation.
    set_in(1'b0, 1'b0, 1'b1);
    sp_edge();
    check("pre_clear_error", 1'b1);
    pulse_reset();
    check("mid_frame_clear", 1'b0);
    set_in(1'b1, 1'b0, 1'b1);
    sp_edge();
    check("stays_clear_1", 1'b0);
    set_in(1'b0, 1'b0, 1'b0);
    sp_edge();
    check("stays_clear_2", 1'b0);
    set_in(1'b0, 1'b1, 1'b0);
    sp_edge();
    check("next_violation", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
